// File: rtl/ascon_pkg.sv
// Shared types and constants for the ASCON-128 control slice.
// Holds the controller state encoding, the round-counter landmarks and a width helper.
// No logic; imported by ascon_ctrl_fsm.
package ascon_pkg;

  typedef enum logic [3:0] {
    IDLE       = 4'd0,
    INIT_CONF  = 4'd1,
    INIT_PERM  = 4'd2,
    AD_WAIT    = 4'd3,
    AD_PERM    = 4'd4,
    PT_WAIT    = 4'd5,
    PT_PERM    = 4'd6,
    FINAL_PERM = 4'd7,
    DONE       = 4'd8
  } state_t;

  // Round-counter landmarks: p12 starts at 0, p6 starts at 6, both end at 11.
  localparam logic [3:0] ROUND_P12_FIRST = 4'd0;
  localparam logic [3:0] ROUND_P6_FIRST  = 4'd6;
  localparam logic [3:0] ROUND_LAST      = 4'd11;

  // Bits needed to count blocks 0..n_max inclusive.
  function automatic int blk_cnt_width(input int n_max);
    return (n_max < 1) ? 1 : $clog2(n_max + 1);
  endfunction

endpackage

// File: rtl/ascon_ctrl_fsm.sv
// Sequences one ASCON-128 AEAD operation (init, AD blocks, PT blocks, final/tag).
// Outputs decode the current state, round_i and data_valid_i combinationally; state moves each core cycle.
// WAIT states hold with data_ready_o=1 until data_valid_i; optional abort via ASCON_CTRL_ABORT_EN.
module ascon_ctrl_fsm
  import ascon_pkg::*;
#(
  parameter int N_AD_BLOCKS = 1,
  parameter int N_PT_BLOCKS = 4
) (
  input  logic       clock_cpt_i,
  input  logic       reset_i,
  input  logic       start_i,
  input  logic       data_valid_i,
  input  logic [3:0] round_i,
`ifdef ASCON_CTRL_ABORT_EN
  input  logic       abort_i,
`endif
  output logic       cpt_enable_o,
  output logic       cpt_init_a_o,
  output logic       cpt_init_b_o,
  output logic       en_reg_state_o,
  output logic       data_sel_o,
  output logic       xor_data_o,
  output logic       xor_key_begin_o,
  output logic       xor_key_end_o,
  output logic       xor_lsb_end_o,
  output logic       en_cipher_o,
  output logic       en_tag_o,
  output logic       data_ready_o,
  output logic       busy_o,
  output logic       end_o
);

  localparam int BW = blk_cnt_width((N_AD_BLOCKS > N_PT_BLOCKS) ? N_AD_BLOCKS : N_PT_BLOCKS);
  // AD count is checked after its increment, PT count before it.
  localparam logic [BW-1:0] AD_LAST     = BW'(N_AD_BLOCKS);
  localparam logic [BW-1:0] PT_LAST_PRE = BW'(N_PT_BLOCKS - 1);

  state_t          r_state;
  logic [BW-1:0]   r_blk_cnt;
  state_t          w_state_nxt;
  logic [BW-1:0]   w_blk_cnt_nxt;

  // State and block counter registers.
  always_ff @(posedge clock_cpt_i or negedge reset_i) begin
    if (!reset_i) begin
      r_state   <= IDLE;
      r_blk_cnt <= '0;
    end else begin
      r_state   <= w_state_nxt;
      r_blk_cnt <= w_blk_cnt_nxt;
    end
  end

  // Next-state and output decode.
  always_comb begin
    w_state_nxt     = r_state;
    w_blk_cnt_nxt   = r_blk_cnt;
    cpt_enable_o    = 1'b0;
    cpt_init_a_o    = 1'b0;
    cpt_init_b_o    = 1'b0;
    en_reg_state_o  = 1'b0;
    data_sel_o      = 1'b0;
    xor_data_o      = 1'b0;
    xor_key_begin_o = 1'b0;
    xor_key_end_o   = 1'b0;
    xor_lsb_end_o   = 1'b0;
    en_cipher_o     = 1'b0;
    en_tag_o        = 1'b0;
    data_ready_o    = 1'b0;
    busy_o          = (r_state != IDLE);
    end_o           = 1'b0;

    case (r_state)
      IDLE: begin
        if (start_i) w_state_nxt = INIT_CONF;
      end
      INIT_CONF: begin
        cpt_enable_o   = 1'b1;
        cpt_init_a_o   = 1'b1;
        en_reg_state_o = 1'b1;
        w_state_nxt    = INIT_PERM;
      end
      INIT_PERM: begin
        cpt_enable_o   = 1'b1;
        en_reg_state_o = 1'b1;
        data_sel_o     = 1'b1;
        if (round_i == ROUND_LAST) begin
          xor_key_end_o = 1'b1;
          w_state_nxt   = AD_WAIT;
          w_blk_cnt_nxt = '0;
        end
      end
      AD_WAIT: begin
        data_ready_o = 1'b1;
        if (data_valid_i) begin
          cpt_enable_o  = 1'b1;
          cpt_init_b_o  = 1'b1;
          w_blk_cnt_nxt = r_blk_cnt + BW'(1);
          w_state_nxt   = AD_PERM;
        end
      end
      AD_PERM: begin
        cpt_enable_o   = 1'b1;
        en_reg_state_o = 1'b1;
        data_sel_o     = 1'b1;
        if (round_i == ROUND_P6_FIRST) xor_data_o = 1'b1;
        if (round_i == ROUND_LAST) begin
          if (r_blk_cnt == AD_LAST) begin
            xor_lsb_end_o = 1'b1;
            w_state_nxt   = PT_WAIT;
            w_blk_cnt_nxt = '0;
          end else begin
            w_state_nxt   = AD_WAIT;
          end
        end
      end
      PT_WAIT: begin
        data_ready_o = 1'b1;
        if (data_valid_i) begin
          cpt_enable_o  = 1'b1;
          w_blk_cnt_nxt = r_blk_cnt + BW'(1);
          if (r_blk_cnt == PT_LAST_PRE) begin
            cpt_init_a_o = 1'b1;
            w_state_nxt  = FINAL_PERM;
          end else begin
            cpt_init_b_o = 1'b1;
            w_state_nxt  = PT_PERM;
          end
        end
      end
      PT_PERM: begin
        cpt_enable_o   = 1'b1;
        en_reg_state_o = 1'b1;
        data_sel_o     = 1'b1;
        if (round_i == ROUND_P6_FIRST) begin
          xor_data_o  = 1'b1;
          en_cipher_o = 1'b1;
        end
        if (round_i == ROUND_LAST) w_state_nxt = PT_WAIT;
      end
      FINAL_PERM: begin
        cpt_enable_o   = 1'b1;
        en_reg_state_o = 1'b1;
        data_sel_o     = 1'b1;
        // The last plaintext block is absorbed on the first round of p12.
        if (round_i == ROUND_P12_FIRST) begin
          xor_data_o      = 1'b1;
          xor_key_begin_o = 1'b1;
          en_cipher_o     = 1'b1;
        end
        if (round_i == ROUND_LAST) begin
          xor_key_end_o = 1'b1;
          en_tag_o      = 1'b1;
          w_state_nxt   = DONE;
        end
      end
      DONE: begin
        end_o       = 1'b1;
        w_state_nxt = IDLE;
      end
      default: begin
        w_state_nxt   = IDLE;
        w_blk_cnt_nxt = '0;
      end
    endcase

`ifdef ASCON_CTRL_ABORT_EN
    // Abort wins over everything: silence the datapath this cycle and drop to IDLE.
    if (abort_i && (r_state != IDLE)) begin
      w_state_nxt     = IDLE;
      w_blk_cnt_nxt   = '0;
      cpt_enable_o    = 1'b0;
      cpt_init_a_o    = 1'b0;
      cpt_init_b_o    = 1'b0;
      en_reg_state_o  = 1'b0;
      data_sel_o      = 1'b0;
      xor_data_o      = 1'b0;
      xor_key_begin_o = 1'b0;
      xor_key_end_o   = 1'b0;
      xor_lsb_end_o   = 1'b0;
      en_cipher_o     = 1'b0;
      en_tag_o        = 1'b0;
      data_ready_o    = 1'b0;
      busy_o          = 1'b0;
      end_o           = 1'b0;
    end
`endif
  end

endmodule

// File: tb/tb_ascon_ctrl_fsm.sv
// Bench for ascon_ctrl_fsm: default instance plus an N_AD=2/N_PT=1 instance, each driving a round counter.
// Directed scenarios: reset, nominal run, stall, boundary, and abort when ASCON_CTRL_ABORT_EN is set.
// Outputs sampled on the falling edge.
module tb_ascon_ctrl_fsm;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n;
  logic start1, dv1, start2, dv2;
`ifdef ASCON_CTRL_ABORT_EN
  logic abort1, abort2;
`endif

  logic en1, ia1, ib1, reg1, sel1, xd1, kb1, ke1, lsb1, ci1, tag1, rdy1, busy1, end1;
  logic en2, ia2, ib2, reg2, sel2, xd2, kb2, ke2, lsb2, ci2, tag2, rdy2, busy2, end2;
  logic [3:0] cnt1, cnt2;

  wire [13:0] out1 = {en1, ia1, ib1, reg1, sel1, xd1, kb1, ke1, lsb1, ci1, tag1, rdy1, busy1, end1};
  wire [13:0] out2 = {en2, ia2, ib2, reg2, sel2, xd2, kb2, ke2, lsb2, ci2, tag2, rdy2, busy2, end2};

  int n_tests = 0;
  int n_fail  = 0;

  // Round counters: init_a loads 0, init_b loads 6, plain enable increments.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt1 <= 4'd0;
    else if (en1) cnt1 <= ia1 ? 4'd0 : (ib1 ? 4'd6 : cnt1 + 4'd1);
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt2 <= 4'd0;
    else if (en2) cnt2 <= ia2 ? 4'd0 : (ib2 ? 4'd6 : cnt2 + 4'd1);
  end

  ascon_ctrl_fsm dut1 (
    .clock_cpt_i(clk), .reset_i(rst_n), .start_i(start1), .data_valid_i(dv1), .round_i(cnt1),
`ifdef ASCON_CTRL_ABORT_EN
    .abort_i(abort1),
`endif
    .cpt_enable_o(en1), .cpt_init_a_o(ia1), .cpt_init_b_o(ib1), .en_reg_state_o(reg1),
    .data_sel_o(sel1), .xor_data_o(xd1), .xor_key_begin_o(kb1), .xor_key_end_o(ke1),
    .xor_lsb_end_o(lsb1), .en_cipher_o(ci1), .en_tag_o(tag1), .data_ready_o(rdy1),
    .busy_o(busy1), .end_o(end1)
  );

  ascon_ctrl_fsm #(.N_AD_BLOCKS(2), .N_PT_BLOCKS(1)) dut2 (
    .clock_cpt_i(clk), .reset_i(rst_n), .start_i(start2), .data_valid_i(dv2), .round_i(cnt2),
`ifdef ASCON_CTRL_ABORT_EN
    .abort_i(abort2),
`endif
    .cpt_enable_o(en2), .cpt_init_a_o(ia2), .cpt_init_b_o(ib2), .en_reg_state_o(reg2),
    .data_sel_o(sel2), .xor_data_o(xd2), .xor_key_begin_o(kb2), .xor_key_end_o(ke2),
    .xor_lsb_end_o(lsb2), .en_cipher_o(ci2), .en_tag_o(tag2), .data_ready_o(rdy2),
    .busy_o(busy2), .end_o(end2)
  );

  task automatic test_reset();
    rst_n = 1'b0;
    #12;
    n_tests++;
    if (out1 !== 14'd0) begin n_fail++; $display("FAIL reset_out1: got %b, want 0", out1); end
    n_tests++;
    if (out2 !== 14'd0) begin n_fail++; $display("FAIL reset_out2: got %b, want 0", out2); end
    @(negedge clk); rst_n = 1'b1;
    @(negedge clk);
    n_tests++;
    if (busy1 !== 1'b0) begin n_fail++; $display("FAIL reset_idle: busy got %b, want 0", busy1); end
    dv1 = 1'b1; start1 = 1'b1;
    @(negedge clk); start1 = 1'b0;      // INIT_CONF
    @(negedge clk); @(negedge clk);     // INIT_PERM round 1
    n_tests++;
    if ({en1, reg1, sel1, busy1} !== 4'b1111)
      begin n_fail++; $display("FAIL init_perm_ctrl: got %b, want 1111", {en1, reg1, sel1, busy1}); end
    #2 rst_n = 1'b0;
    #1;
    n_tests++;
    if (out1 !== 14'd0) begin n_fail++; $display("FAIL reset_mid_op: got %b, want 0", out1); end
    @(negedge clk); rst_n = 1'b1;
    @(negedge clk);
    n_tests++;
    if (busy1 !== 1'b0) begin n_fail++; $display("FAIL reset_stays_idle: busy got %b, want 0", busy1); end
  endtask

  task automatic test_nominal();
    int cyc, nci, nlsb, nke, ntag, nkb;
    bit done;
    cyc = 0; nci = 0; nlsb = 0; nke = 0; ntag = 0; nkb = 0; done = 1'b0;
    dv1 = 1'b1;
    @(negedge clk); start1 = 1'b1;
    @(negedge clk); start1 = 1'b0;
    n_tests++;
    if ({ia1, reg1, sel1} !== 3'b110)
      begin n_fail++; $display("FAIL init_conf: got %b, want 110", {ia1, reg1, sel1}); end
    for (int i = 0; i < 200; i++) begin
      if (end1) begin done = 1'b1; break; end
      if (busy1) cyc++;
      nci += int'(ci1); nlsb += int'(lsb1); nke += int'(ke1); ntag += int'(tag1); nkb += int'(kb1);
      @(negedge clk);
    end
    n_tests++;
    if (!done) begin n_fail++; $display("FAIL nominal_done: end_o got 0, want 1"); end
    n_tests++;
    if (cyc != 54) begin n_fail++; $display("FAIL nominal_cycles: got %0d, want 54", cyc); end
    n_tests++;
    if (nci != 4) begin n_fail++; $display("FAIL en_cipher_count: got %0d, want 4", nci); end
    n_tests++;
    if (nlsb != 1) begin n_fail++; $display("FAIL xor_lsb_end_count: got %0d, want 1", nlsb); end
    n_tests++;
    if (nke != 2) begin n_fail++; $display("FAIL xor_key_end_count: got %0d, want 2", nke); end
    n_tests++;
    if (ntag != 1) begin n_fail++; $display("FAIL en_tag_count: got %0d, want 1", ntag); end
    n_tests++;
    if (nkb != 1) begin n_fail++; $display("FAIL xor_key_begin_count: got %0d, want 1", nkb); end
    @(negedge clk);
    n_tests++;
    if ({end1, busy1} !== 2'b00)
      begin n_fail++; $display("FAIL end_pulse_width: end,busy got %b, want 00", {end1, busy1}); end
  endtask

  task automatic test_stall();
    logic [3:0] held;
    bit seen, done;
    seen = 1'b0; done = 1'b0;
    dv1 = 1'b1;
    @(negedge clk); start1 = 1'b1;
    @(negedge clk); start1 = 1'b0;
    for (int i = 0; i < 100; i++) begin
      if (lsb1) begin seen = 1'b1; dv1 = 1'b0; break; end
      @(negedge clk);
    end
    n_tests++;
    if (!seen) begin n_fail++; $display("FAIL stall_reach_pt: xor_lsb_end got 0, want 1"); end
    @(negedge clk);                      // PT_WAIT, no valid
    held = cnt1;
    n_tests++;
    if (held !== 4'd12) begin n_fail++; $display("FAIL stall_cnt_at_wait: got %0d, want 12", held); end
    for (int k = 0; k < 5; k++) begin
      n_tests++;
      if ({rdy1, en1, ia1, ib1, busy1} !== 5'b10001 || cnt1 !== held)
        begin n_fail++; $display("FAIL stall_hold[%0d]: rdy,en,ia,ib,busy=%b cnt=%0d, want 10001 cnt=%0d",
                                 k, {rdy1, en1, ia1, ib1, busy1}, cnt1, held); end
      @(negedge clk);
    end
    dv1 = 1'b1;
    #1;
    n_tests++;
    if ({en1, ia1, ib1} !== 3'b101)
      begin n_fail++; $display("FAIL stall_resume: en,ia,ib got %b, want 101", {en1, ia1, ib1}); end
    @(negedge clk);
    n_tests++;
    if (cnt1 !== 4'd6) begin n_fail++; $display("FAIL stall_resume_cnt: got %0d, want 6", cnt1); end
    for (int i = 0; i < 100; i++) begin
      if (end1) begin done = 1'b1; break; end
      @(negedge clk);
    end
    n_tests++;
    if (!done) begin n_fail++; $display("FAIL stall_completes: end_o got 0, want 1"); end
    @(negedge clk);
  endtask

  task automatic test_boundary();
    int cyc, hs, hs_at_lsb, nlsb, nxd_ad;
    logic [2:0] pt_ctrl;
    logic kb_next;
    bit lsb_seen, pt_hs, grab_kb, done;
    cyc = 0; hs = 0; hs_at_lsb = -1; nlsb = 0; nxd_ad = 0;
    pt_ctrl = 3'b000; kb_next = 1'b0; lsb_seen = 1'b0; pt_hs = 1'b0; grab_kb = 1'b0; done = 1'b0;
    dv2 = 1'b1;
    @(negedge clk); start2 = 1'b1;
    @(negedge clk); start2 = 1'b0;
    for (int i = 0; i < 200; i++) begin
      if (end2) begin done = 1'b1; break; end
      if (busy2) cyc++;
      if (grab_kb) begin kb_next = kb2; grab_kb = 1'b0; end
      if (!lsb_seen && xd2) nxd_ad++;
      if (lsb2) begin nlsb++; hs_at_lsb = hs; lsb_seen = 1'b1; end
      if (rdy2 && dv2) begin
        hs++;
        if (lsb_seen && !pt_hs) begin pt_hs = 1'b1; pt_ctrl = {en2, ia2, ib2}; grab_kb = 1'b1; end
      end
      @(negedge clk);
    end
    n_tests++;
    if (!done) begin n_fail++; $display("FAIL bnd_done: end_o got 0, want 1"); end
    n_tests++;
    if (cyc != 40) begin n_fail++; $display("FAIL bnd_cycles: got %0d, want 40", cyc); end
    n_tests++;
    if (nxd_ad != 2) begin n_fail++; $display("FAIL bnd_ad_passes: got %0d, want 2", nxd_ad); end
    n_tests++;
    if (nlsb != 1 || hs_at_lsb != 2)
      begin n_fail++; $display("FAIL bnd_lsb_second: count %0d after %0d AD blocks, want 1 after 2", nlsb, hs_at_lsb); end
    n_tests++;
    if (pt_ctrl !== 3'b110) begin n_fail++; $display("FAIL bnd_pt_init_a: en,ia,ib got %b, want 110", pt_ctrl); end
    n_tests++;
    if (kb_next !== 1'b1) begin n_fail++; $display("FAIL bnd_final_first: xor_key_begin got %b, want 1", kb_next); end
    @(negedge clk);
  endtask

`ifdef ASCON_CTRL_ABORT_EN
  task automatic test_abort();
    bit hit, ended, done;
    int cyc;
    hit = 1'b0; ended = 1'b0; done = 1'b0; cyc = 0;
    dv1 = 1'b1;
    @(negedge clk); start1 = 1'b1;
    @(negedge clk); start1 = 1'b0;
    for (int i = 0; i < 100; i++) begin
      // AD_PERM round 8: en_reg_state without data_sel=0, after AD handshake; detect via counter and busy
      if (busy1 && reg1 && cnt1 == 4'd8 && !rdy1 && i > 13) begin hit = 1'b1; break; end
      @(negedge clk);
    end
    n_tests++;
    if (!hit) begin n_fail++; $display("FAIL abort_reach: AD_PERM round 8 not seen"); end
    abort1 = 1'b1;
    #1;
    n_tests++;
    if (out1 !== 14'd0) begin n_fail++; $display("FAIL abort_suppress: got %b, want 0", out1); end
    @(negedge clk); abort1 = 1'b0;
    for (int k = 0; k < 4; k++) begin
      if (end1 || busy1) ended = 1'b1;
      @(negedge clk);
    end
    n_tests++;
    if (ended) begin n_fail++; $display("FAIL abort_idle: end/busy seen after abort, want none"); end
    start1 = 1'b1;
    @(negedge clk); start1 = 1'b0;
    for (int i = 0; i < 200; i++) begin
      if (end1) begin done = 1'b1; break; end
      if (busy1) cyc++;
      @(negedge clk);
    end
    n_tests++;
    if (!done || cyc != 54)
      begin n_fail++; $display("FAIL abort_restart: done=%0d cycles=%0d, want 1 and 54", done, cyc); end
    @(negedge clk);
  endtask
`endif

  initial begin
    start1 = 1'b0; dv1 = 1'b0; start2 = 1'b0; dv2 = 1'b0;
`ifdef ASCON_CTRL_ABORT_EN
    abort1 = 1'b0; abort2 = 1'b0;
`endif
    test_reset();
    test_nominal();
    test_stall();
    test_boundary();
`ifdef ASCON_CTRL_ABORT_EN
    test_abort();
`endif
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
